// File: rtl/lrsc_pkg.sv
// lrsc_pkg: shared request types, reservation record and timeout sizing for the LR/SC reservation unit
package lrsc_pkg;
  localparam int LRSC_ADDR_W = 30;
  localparam int TIMEOUT_CYCLES_DEF = 1024;
  localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES_DEF);
  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_LR   = 2'b01,
    REQ_SC   = 2'b10,
    REQ_ST   = 2'b11
  } req_type_e;
  typedef struct packed {
    logic                   valid;
    logic [LRSC_ADDR_W-1:0] addr;
  } resv_entry_t;
endpackage

// File: rtl/lrsc_resv_entry.sv
// lrsc_resv_entry: one hart's reservation (valid + word address, optional lifetime counter)
// Ports: set_i loads addr_i, clear_i drops the reservation, snoop_i/snoop_addr_i invalidate on
// an address hit; valid_o is the registered state, match_o is a live reservation equal to addr_i.
// LRSC_TIMEOUT_EN adds a countdown that expires the reservation after TIMEOUT_CYCLES.
module lrsc_resv_entry
  import lrsc_pkg::*;
#(
  parameter int ADDR_W = LRSC_ADDR_W
`ifdef LRSC_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              snoop_i,
  input  logic [ADDR_W-1:0] snoop_addr_i,
  output logic              valid_o,
  output logic              match_o
);
  logic              valid_q, valid_d, live, snoop_hit;
  logic [ADDR_W-1:0] addr_q;
`ifdef LRSC_TIMEOUT_EN
  localparam int CNT_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q;
  // a reservation whose counter has reached zero is already dead this cycle
  assign live = valid_q && cnt_q != '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else if (set_i) cnt_q <= CNT_W'(TIMEOUT_CYCLES - 1);
    else if (live) cnt_q <= cnt_q - 1'b1;
`else
  assign live = valid_q;
`endif
  // an LR is killed by a snoop to the address it is loading, otherwise the snoop hits the stored one
  assign snoop_hit = snoop_i && snoop_addr_i == (set_i ? addr_i : addr_q);
  assign valid_d   = set_i ? !snoop_hit : live && !clear_i && !snoop_hit;
  assign match_o   = live && addr_q == addr_i;
  assign valid_o   = valid_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (set_i) addr_q <= addr_i;
    end
endmodule

// File: rtl/lrsc_reservation_unit.sv
// lrsc_reservation_unit: per-hart LR/SC reservation tracker with registered SC verdict
// Ports: i_req_* is the single memory-stage request (type 01 LR, 10 SC, 11 store), i_snoop_*
// an external bus write; o_sc_* is the SC verdict one cycle after the SC, o_resv_valid the
// per-hart reservation state. LRSC_TIMEOUT_EN enables reservation expiry after TIMEOUT_CYCLES.
module lrsc_reservation_unit
  import lrsc_pkg::*;
#(
  parameter int NUM_HARTS = 16,
  parameter int HART_ID_W = $clog2(NUM_HARTS),
  parameter int ADDR_W    = LRSC_ADDR_W
`ifdef LRSC_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req_valid,
  input  logic [1:0]           i_req_type,
  input  logic [HART_ID_W-1:0] i_req_hart,
  input  logic [ADDR_W-1:0]    i_req_addr,
  input  logic                 i_snoop_valid,
  input  logic [ADDR_W-1:0]    i_snoop_addr,
  output logic                 o_sc_valid,
  output logic [HART_ID_W-1:0] o_sc_hart,
  output logic                 o_sc_success,
  output logic                 o_sc_rd,
  output logic [NUM_HARTS-1:0] o_resv_valid
);
  logic                 req_lr, req_sc, req_st, sc_ok, store;
  logic [NUM_HARTS-1:0] sel, match;
  logic                 sc_valid_q, sc_success_q;
  logic [HART_ID_W-1:0] sc_hart_q;
  assign req_lr = i_req_valid && i_req_type == REQ_LR;
  assign req_sc = i_req_valid && i_req_type == REQ_SC;
  assign req_st = i_req_valid && i_req_type == REQ_ST;
  // sel is all-zero for an out-of-range hart, so such an SC can never succeed
  assign sc_ok  = req_sc && |(sel & match) && !(i_snoop_valid && i_snoop_addr == i_req_addr);
  assign store  = req_st || sc_ok;
  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_entry
    assign sel[h] = i_req_hart == HART_ID_W'(h);
    lrsc_resv_entry #(
      .ADDR_W(ADDR_W)
`ifdef LRSC_TIMEOUT_EN
      , .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
    ) u_entry (
      .clk         (clk),
      .reset_n     (reset_n),
      .set_i       (req_lr && sel[h]),
      .clear_i     ((req_sc && sel[h]) || (store && !sel[h] && match[h])),
      .addr_i      (i_req_addr),
      .snoop_i     (i_snoop_valid),
      .snoop_addr_i(i_snoop_addr),
      .valid_o     (o_resv_valid[h]),
      .match_o     (match[h])
    );
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sc_valid_q   <= 1'b0;
      sc_success_q <= 1'b0;
      sc_hart_q    <= '0;
    end else begin
      sc_valid_q   <= req_sc;
      sc_success_q <= sc_ok;
      if (req_sc) sc_hart_q <= i_req_hart;
    end
  assign o_sc_valid   = sc_valid_q;
  assign o_sc_hart    = sc_hart_q;
  assign o_sc_success = sc_success_q;
  assign o_sc_rd      = !sc_success_q;
endmodule

// File: tb/tb_lrsc_reservation_unit.sv
// tb_lrsc_reservation_unit: directed self-checking bench for the LR/SC reservation unit
module tb_lrsc_reservation_unit;
  localparam logic [1:0] LR = 2'b01, SC = 2'b10, ST = 2'b11;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic [1:0]  i_req_type = 2'b00;
  logic [3:0]  i_req_hart = '0;
  logic [29:0] i_req_addr = '0;
  logic        i_snoop_valid = 1'b0;
  logic [29:0] i_snoop_addr = '0;
  logic        o_sc_valid, o_sc_success, o_sc_rd;
  logic [3:0]  o_sc_hart;
  logic [15:0] o_resv_valid;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  lrsc_reservation_unit #(
    .NUM_HARTS(16)
`ifdef LRSC_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req_valid(i_req_valid), .i_req_type(i_req_type), .i_req_hart(i_req_hart),
    .i_req_addr(i_req_addr), .i_snoop_valid(i_snoop_valid), .i_snoop_addr(i_snoop_addr),
    .o_sc_valid(o_sc_valid), .o_sc_hart(o_sc_hart), .o_sc_success(o_sc_success),
    .o_sc_rd(o_sc_rd), .o_resv_valid(o_resv_valid)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic req(input logic [1:0] t, input int h, input int a, input logic sv = 1'b0, input int sa = 0);
    i_req_valid   = 1'b1;
    i_req_type    = t;
    i_req_hart    = 4'(h);
    i_req_addr    = 30'(a);
    i_snoop_valid = sv;
    i_snoop_addr  = 30'(sa);
    @(posedge clk);
    #1;
    i_req_valid   = 1'b0;
    i_req_type    = 2'b00;
    i_snoop_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic verdict(input string tag, input int h, input logic ok);
    chk({tag, "_valid"}, {31'd0, o_sc_valid}, 32'd1);
    chk({tag, "_hart"}, {28'd0, o_sc_hart}, 32'(h));
    chk({tag, "_success"}, {31'd0, o_sc_success}, {31'd0, ok});
    chk({tag, "_rd"}, {31'd0, o_sc_rd}, {31'd0, !ok});
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_valid"}, {31'd0, o_sc_valid}, 32'd0);
    chk({tag, "_hart"}, {28'd0, o_sc_hart}, 32'd0);
    chk({tag, "_success"}, {31'd0, o_sc_success}, 32'd0);
    chk({tag, "_rd"}, {31'd0, o_sc_rd}, 32'd1);
    chk({tag, "_resv"}, {16'd0, o_resv_valid}, 32'd0);
  endtask
  initial begin
    #2;
    reset_vals("rst");
    idle(2);
    reset_n = 1'b1;
    idle(1);
    req(LR, 3, 'h100);
    chk("t1_resv_set", {16'd0, o_resv_valid}, 32'h0008);
    req(SC, 3, 'h100);
    verdict("t1", 3, 1'b1);
    chk("t1_resv_clr", {16'd0, o_resv_valid}, 32'h0000);
    idle(1);
    chk("t1_pulse", {31'd0, o_sc_valid}, 32'd0);
    req(LR, 2, 'h40);
    req(ST, 5, 'h40);
    chk("t2_st_clr", {16'd0, o_resv_valid}, 32'h0000);
    req(SC, 2, 'h40);
    verdict("t2", 2, 1'b0);
    req(LR, 2, 'h44);
    req(ST, 2, 'h44);
    chk("own_st_keep", {16'd0, o_resv_valid}, 32'h0004);
    req(SC, 2, 'h44);
    verdict("own_st", 2, 1'b1);
    req(LR, 1, 'h80);
    req(LR, 4, 'h80);
    chk("t3_two", {16'd0, o_resv_valid}, 32'h0012);
    req(SC, 1, 'h80);
    verdict("t3_h1", 1, 1'b1);
    chk("t3_h4_clr", {16'd0, o_resv_valid}, 32'h0000);
    req(SC, 4, 'h80);
    verdict("t3_h4", 4, 1'b0);
    req(LR, 0, 'h10);
    req(SC, 0, 'h10, 1'b1, 'h10);
    verdict("t4_snp_hit", 0, 1'b0);
    req(LR, 0, 'h10);
    req(SC, 0, 'h10, 1'b1, 'h14);
    verdict("t4_snp_miss", 0, 1'b1);
    req(LR, 8, 'h50, 1'b1, 'h50);
    chk("lr_snoop", {16'd0, o_resv_valid}, 32'h0000);
    req(LR, 9, 'h60, 1'b1, 'h61);
    chk("lr_snoop_miss", {16'd0, o_resv_valid}, 32'h0200);
    i_snoop_valid = 1'b1;
    i_snoop_addr  = 30'h60;
    idle(1);
    i_snoop_valid = 1'b0;
    chk("snoop_clr", {16'd0, o_resv_valid}, 32'h0000);
    req(LR, 10, 'h70);
    req(SC, 10, 'h71);
    verdict("addr_mis", 10, 1'b0);
    chk("addr_mis_clr", {16'd0, o_resv_valid}, 32'h0000);
    req(LR, 6, 'h20);
    chk("t5_set", {16'd0, o_resv_valid}, 32'h0040);
    reset_n = 1'b0;
    #2;
    reset_vals("t5_rst");
    idle(1);
    reset_n = 1'b1;
    req(SC, 6, 'h20);
    verdict("t5", 6, 1'b0);
`ifdef LRSC_TIMEOUT_EN
    req(LR, 7, 'h30);
    idle(6);
    req(SC, 7, 'h30);
    verdict("t6_in_time", 7, 1'b1);
    req(LR, 7, 'h30);
    idle(7);
    chk("t6_last", {16'd0, o_resv_valid}, 32'h0080);
    req(SC, 7, 'h30);
    verdict("t6_expired", 7, 1'b0);
`else
    req(LR, 7, 'h30);
    idle(40);
    chk("persist", {16'd0, o_resv_valid}, 32'h0080);
    req(SC, 7, 'h30);
    verdict("persist", 7, 1'b1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
